// File: rtl/branch_pattern_table_if.sv
// Fetch-lookup and MEM-update signals of the branch pattern table.
// The master is the pipeline side; the slave is the table itself.
interface branch_pattern_table_if;
    logic [31:0] if_pc;
    logic [1:0]  if_prediction;
    logic        if_predict_taken;
    logic [31:0] mem_pc;
    logic        load_prediction;
    logic [1:0]  mem_updated_prediction;
    logic        ready;

    modport master (
        output if_pc,
        output mem_pc,
        output load_prediction,
        output mem_updated_prediction,
        input  if_prediction,
        input  if_predict_taken,
        input  ready
    );

    modport slave (
        input  if_pc,
        input  mem_pc,
        input  load_prediction,
        input  mem_updated_prediction,
        output if_prediction,
        output if_predict_taken,
        output ready
    );
endinterface

// File: rtl/branch_pattern_table.sv
// Direct-mapped table of 2-bit branch counters with combinational lookup,
// same-cycle forwarding of MEM updates, and a post-reset weakly-not-taken sweep.
module branch_pattern_table #(
    parameter int IDX_WIDTH = 5,
    parameter int PC_LSB    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_pattern_table_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = {IDX_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IDX_WIDTH-1:0] sweep_idx_r;
    logic                 ready_r;
    logic [1:0]           table_r [DEPTH];

    logic [IDX_WIDTH-1:0] if_idx_s;
    logic [IDX_WIDTH-1:0] mem_idx_s;
    logic                 wr_en_s;
    logic [IDX_WIDTH-1:0] wr_idx_s;
    logic [1:0]           wr_data_s;
    logic [1:0]           prediction_s;

    assign if_idx_s  = bus.if_pc[PC_LSB +: IDX_WIDTH];
    assign mem_idx_s = bus.mem_pc[PC_LSB +: IDX_WIDTH];

    // Next-state logic: sweep until the last entry is written, then run forever.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_idx_r == LAST_IDX) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // Single write port: the sweep owns it in INIT, MEM updates own it in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = {IDX_WIDTH{1'b0}};
        wr_data_s = 2'b00;
        case (state_r)
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = sweep_idx_r;
                wr_data_s = 2'b01;
            end
            ST_RUN: begin
                wr_en_s   = bus.load_prediction;
                wr_idx_s  = mem_idx_s;
                wr_data_s = bus.mem_updated_prediction;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_idx_s  = {IDX_WIDTH{1'b0}};
                wr_data_s = 2'b00;
            end
        endcase
    end

    // Lookup: fixed weakly-not-taken while sweeping, forwarded update on index hit.
    always_comb begin
        prediction_s = 2'b01;
        if (state_r == ST_RUN) begin
            if (bus.load_prediction && (if_idx_s == mem_idx_s)) begin
                prediction_s = bus.mem_updated_prediction;
            end else begin
                prediction_s = table_r[if_idx_s];
            end
        end else begin
            prediction_s = 2'b01;
        end
    end

    // Control registers; ready follows the next state so it rises right after the last sweep write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_INIT;
            sweep_idx_r <= {IDX_WIDTH{1'b0}};
            ready_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_RUN);
            if (state_r == ST_INIT) begin
                sweep_idx_r <= sweep_idx_r + IDX_WIDTH'(1);
            end else begin
                sweep_idx_r <= sweep_idx_r;
            end
        end
    end

    // Counter storage has no reset; the sweep defines every entry before use.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            table_r[wr_idx_s] <= wr_data_s;
        end
    end

    assign bus.if_prediction    = prediction_s;
    assign bus.if_predict_taken = prediction_s[1] & ready_r;
    assign bus.ready            = ready_r;
endmodule

// File: tb/tb_branch_pattern_table.sv
// Directed bench for branch_pattern_table: default geometry plus a
// 3-bit-index / PC_LSB=1 instance sharing clock and reset.
module tb_branch_pattern_table;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    branch_pattern_table_if bus0 ();
    branch_pattern_table_if bus1 ();

    branch_pattern_table #(.IDX_WIDTH(5), .PC_LSB(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    branch_pattern_table #(.IDX_WIDTH(3), .PC_LSB(1)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        bus0.if_pc = 32'h0000_0008;
        bus0.mem_pc = 32'h0000_0008;
        bus0.load_prediction = 1'b1;
        bus0.mem_updated_prediction = 2'b11;
        bus1.if_pc = 32'h0000_0000;
        bus1.mem_pc = 32'h0000_0000;
        bus1.load_prediction = 1'b0;
        bus1.mem_updated_prediction = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b exp=0", bus0.ready);
        end
        checks++;
        if (bus0.if_prediction !== 2'b01) begin
            failures++; $display("FAIL reset_prediction got=%b exp=01", bus0.if_prediction);
        end
        checks++;
        if (bus0.if_predict_taken !== 1'b0) begin
            failures++; $display("FAIL reset_taken got=%b exp=0", bus0.if_predict_taken);
        end
        checks++;
        if (bus1.ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready_small got=%b exp=0", bus1.ready);
        end
        // Release between edges; load stays high through the whole sweep so it must be dropped.
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus0.ready !== (i == 31)) begin
                failures++; $display("FAIL sweep_ready edge=%0d got=%b exp=%b", i + 1, bus0.ready, (i == 31));
            end
            checks++;
            if (bus1.ready !== (i >= 7)) begin
                failures++; $display("FAIL sweep_ready_small edge=%0d got=%b exp=%b", i + 1, bus1.ready, (i >= 7));
            end
            if (i < 31) begin
                checks++;
                if (bus0.if_prediction !== 2'b01) begin
                    failures++; $display("FAIL init_no_forward edge=%0d got=%b exp=01", i + 1, bus0.if_prediction);
                end
            end
            if (i == 31) bus0.load_prediction = 1'b0;
        end
    endtask

    task automatic test_init_values();
        for (int i = 0; i < 32; i++) begin
            bus0.if_pc = 32'(i) << 2;
            #1;
            checks++;
            if (bus0.if_prediction !== 2'b01 || bus0.if_predict_taken !== 1'b0) begin
                failures++; $display("FAIL init_value idx=%0d got=%b/%b exp=01/0", i, bus0.if_prediction, bus0.if_predict_taken);
            end
        end
        bus0.if_pc = 32'h0000_0008;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b01) begin
            failures++; $display("FAIL dropped_init_write got=%b exp=01", bus0.if_prediction);
        end
        for (int i = 0; i < 8; i++) begin
            bus1.if_pc = 32'(i) << 1;
            #1;
            checks++;
            if (bus1.if_prediction !== 2'b01) begin
                failures++; $display("FAIL init_value_small idx=%0d got=%b exp=01", i, bus1.if_prediction);
            end
        end
    endtask

    task automatic test_write_read();
        bus0.mem_pc = 32'h0000_0010;
        bus0.mem_updated_prediction = 2'b11;
        bus0.load_prediction = 1'b1;
        @(posedge clk);
        #1;
        bus0.load_prediction = 1'b0;
        bus0.if_pc = 32'h0000_0010;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b11 || bus0.if_predict_taken !== 1'b1) begin
            failures++; $display("FAIL write_read got=%b/%b exp=11/1", bus0.if_prediction, bus0.if_predict_taken);
        end
        bus0.if_pc = 32'h0000_0014;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b01) begin
            failures++; $display("FAIL write_neighbour got=%b exp=01", bus0.if_prediction);
        end
    endtask

    task automatic test_forwarding();
        bus0.if_pc = 32'h0000_0040;
        bus0.mem_pc = 32'h0000_0040;
        bus0.mem_updated_prediction = 2'b10;
        bus0.load_prediction = 1'b1;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b10 || bus0.if_predict_taken !== 1'b1) begin
            failures++; $display("FAIL forward got=%b/%b exp=10/1", bus0.if_prediction, bus0.if_predict_taken);
        end
        bus0.if_pc = 32'h0000_0044;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b01) begin
            failures++; $display("FAIL forward_other_idx got=%b exp=01", bus0.if_prediction);
        end
        @(posedge clk);
        #1;
        bus0.load_prediction = 1'b0;
        bus0.if_pc = 32'h0000_00C0;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b10) begin
            failures++; $display("FAIL alias_read got=%b exp=10", bus0.if_prediction);
        end
    endtask

    task automatic test_back_to_back();
        bus0.mem_pc = 32'h0000_000C;
        bus0.mem_updated_prediction = 2'b10;
        bus0.load_prediction = 1'b1;
        @(posedge clk);
        #1;
        bus0.mem_pc = 32'h0000_0010;
        bus0.mem_updated_prediction = 2'b00;
        bus0.if_pc = 32'h0000_000C;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b10) begin
            failures++; $display("FAIL b2b_first got=%b exp=10", bus0.if_prediction);
        end
        @(posedge clk);
        #1;
        bus0.load_prediction = 1'b0;
        bus0.if_pc = 32'h0000_0010;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b00 || bus0.if_predict_taken !== 1'b0) begin
            failures++; $display("FAIL b2b_second got=%b/%b exp=00/0", bus0.if_prediction, bus0.if_predict_taken);
        end
    endtask

    task automatic test_mid_reset();
        bus0.mem_pc = 32'h0000_001C;
        bus0.mem_updated_prediction = 2'b00;
        bus0.load_prediction = 1'b1;
        @(posedge clk);
        #1;
        bus0.load_prediction = 1'b0;
        bus0.if_pc = 32'h0000_001C;
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b00) begin
            failures++; $display("FAIL pre_reset_idx7 got=%b exp=00", bus0.if_prediction);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus0.ready !== 1'b0) begin
            failures++; $display("FAIL async_ready got=%b exp=0", bus0.ready);
        end
        checks++;
        if (bus0.if_prediction !== 2'b01) begin
            failures++; $display("FAIL async_prediction got=%b exp=01", bus0.if_prediction);
        end
        checks++;
        if (bus1.ready !== 1'b0) begin
            failures++; $display("FAIL async_ready_small got=%b exp=0", bus1.ready);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus0.ready !== (i == 31)) begin
                failures++; $display("FAIL resweep_ready edge=%0d got=%b exp=%b", i + 1, bus0.ready, (i == 31));
            end
            checks++;
            if (bus1.ready !== (i >= 7)) begin
                failures++; $display("FAIL resweep_ready_small edge=%0d got=%b exp=%b", i + 1, bus1.ready, (i >= 7));
            end
        end
        #1;
        checks++;
        if (bus0.if_prediction !== 2'b01) begin
            failures++; $display("FAIL resweep_idx7 got=%b exp=01", bus0.if_prediction);
        end
    endtask

    task automatic test_param_small();
        bus1.mem_pc = 32'hFFFF_FFFA;
        bus1.mem_updated_prediction = 2'b11;
        bus1.load_prediction = 1'b1;
        @(posedge clk);
        #1;
        bus1.load_prediction = 1'b0;
        bus1.if_pc = 32'h0000_000A;
        #1;
        checks++;
        if (bus1.if_prediction !== 2'b11) begin
            failures++; $display("FAIL small_idx5 got=%b exp=11", bus1.if_prediction);
        end
        bus1.if_pc = 32'h0000_000B;
        #1;
        checks++;
        if (bus1.if_prediction !== 2'b11) begin
            failures++; $display("FAIL small_bit0_ignored got=%b exp=11", bus1.if_prediction);
        end
        bus1.if_pc = 32'h0000_001A;
        #1;
        checks++;
        if (bus1.if_prediction !== 2'b11) begin
            failures++; $display("FAIL small_alias got=%b exp=11", bus1.if_prediction);
        end
        bus1.if_pc = 32'h0000_0008;
        #1;
        checks++;
        if (bus1.if_prediction !== 2'b01) begin
            failures++; $display("FAIL small_idx4 got=%b exp=01", bus1.if_prediction);
        end
        bus1.if_pc = 32'h0000_000C;
        #1;
        checks++;
        if (bus1.if_prediction !== 2'b01) begin
            failures++; $display("FAIL small_idx6 got=%b exp=01", bus1.if_prediction);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_init_values();
        test_write_read();
        test_forwarding();
        test_back_to_back();
        test_mid_reset();
        test_param_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
